i_fetch: RTL and testbench
==========================

# i_fetch

Instruction-fetch stage of the five-stage pipeline, directly upstream of `i_decode`. Holds the program counter and a word-addressed instruction memory, selects the next PC between sequential (PC+4) and the branch target returned from EX/MEM, and registers the fetched instruction and its next-PC into the IF/ID pipeline latch. Supports a hazard stall (hold) and a flush (bubble insertion) so the decode stage always sees a well-defined instruction.

## Interface
- `MEM_DEPTH`, 128: instruction memory depth in 32-bit words; power of two, ≥ 2.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset; word aligned.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `EX_MEM_PCSrc`  in  1  taken branch resolved in MEM; redirect PC.
- `EX_MEM_NPC`  in  32  branch target address; bits [1:0] ignored.
- `stall`  in  1  hazard hold: freeze PC and IF/ID.
- `flush`  in  1  replace next IF/ID contents with NOP.
- `imem_we`  in  1  instruction memory write enable (bench/loader).
- `imem_waddr`  in  log2(MEM_DEPTH)  word index to write.
- `imem_wdata`  in  32  word to write.
- `pc_out`  out  32  current PC.
- `IF_ID_instrout`  out  32  registered instruction, to `i_decode`.
- `IF_ID_npcout`  out  32  registered PC+4 of that instruction, to `i_decode`.
- `IF_ID_valid`  out  1  1 = IF/ID holds a real fetched instruction, 0 = bubble.

## Operation
- Combinational: `npc = pc + 4` (mod 2^32; 32'hFFFF_FFFC wraps to 0). `instr = imem[pc[log2(MEM_DEPTH)+1:2]]` if `pc[31:2] < MEM_DEPTH`, else NOP (32'h0000_0000). `pc[1:0]` ignored on read.
- Per-edge action, strict priority:
  1. `EX_MEM_PCSrc`=1: `pc <= {EX_MEM_NPC[31:2],2'b00}`; IF/ID <= {NOP, npcout 0, valid 0}. Overrides `stall` and `flush`.
  2. `flush`=1: `pc <= npc`; IF/ID <= {NOP, 0, valid 0}. Overrides `stall`; the instruction at the old PC is dropped.
  3. `stall`=1: `pc`, `IF_ID_instrout`, `IF_ID_npcout`, and `IF_ID_valid` all hold.
  4. otherwise: `pc <= npc`; `IF_ID_instrout <= instr`; `IF_ID_npcout <= npc`; `IF_ID_valid <= 1`.
- Memory write is independent of the priority chain: on an edge with `imem_we`=1, `imem[imem_waddr] <= imem_wdata`. A same-edge fetch from that address captures the old word. Memory contents are not reset.
- Reset (async assert, sync-free deassert): `pc_out`=`RESET_PC`, `IF_ID_instrout`=NOP, `IF_ID_npcout`=0, `IF_ID_valid`=0, immediately on `rst_n` falling, including mid-stall or mid-redirect. The first fetch from `RESET_PC` is latched on the first rising edge with `rst_n`=1.

## Timing
- Latency: 1 cycle from PC to IF/ID. Throughput: one instruction per cycle when not stalled.
- Redirect: target instruction appears in IF/ID 2 edges after the `EX_MEM_PCSrc` edge, with exactly one bubble (valid 0) in between.
- A stall held for N cycles freezes outputs for N edges; fetch resumes on the first edge with `stall`=0, and no instruction is duplicated or skipped.
- `pc_out` is a register output; `EX_MEM_*`, `stall`, and `flush` are sampled only at the edge.

## Structure
- Shared pipeline package: `INSTR_W`=32, `NOP_INSTR`=32'h0000_0000, `PC_STEP`=4; `i_decode` uses the same NOP encoding.
- Sub-module `instr_mem`: synchronous write port and asynchronous read port, parameterized by `MEM_DEPTH`. It returns NOP for out-of-range reads.
- PC register, next-PC mux, and IF/ID latch live in `i_fetch`.

## Test plan
- Reset, then load imem[0..3] = A0..A3 and run → IF_ID sequence (A0,4),(A1,8),(A2,12),(A3,16), with valid=1 from the 1st edge after reset release.
- `stall`=1 for 3 cycles while IF/ID=(A1,8) → IF/ID stays (A1,8) and `pc_out` stays 8; the next edge gives (A2,12).
- `EX_MEM_PCSrc`=1, `EX_MEM_NPC`=32'h40, asserted together with `stall`=1 → next edge IF/ID=(NOP,0,valid 0) and pc=0x40; the following edge gives (imem[16],0x44).
- `flush`=1 at pc=8 → IF/ID=(NOP,0,0) and pc=12; the next edge gives (A3,16), so A2 is dropped.
- `RESET_PC`=`MEM_DEPTH*4-4` with the last word=B → first fetch (B,`MEM_DEPTH*4`), then NOP with valid=1 (out of range); also force pc=32'hFFFF_FFFC → npcout=0.
- Write imem[2]=C on the same edge pc=8 is fetched → IF/ID gets the old word; a later redirect to 8 fetches C. Assert `rst_n`=0 mid-run → outputs reset asynchronously, before the next edge.

Source files
------------

// File: rtl/i_fetch_pkg.sv
// Shared pipeline definitions for the fetch/decode stages.
package i_fetch_pkg;

  localparam int unsigned      INSTR_W   = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;
  localparam logic [31:0]      PC_STEP   = 32'd4;

  // Per-edge action of the fetch stage, in increasing priority order.
  typedef enum logic [1:0] {
    ACT_FETCH,
    ACT_HOLD,
    ACT_FLUSH,
    ACT_REDIRECT
  } fetch_act_e;

  // Priority: redirect > flush > stall > normal fetch.
  function automatic fetch_act_e sel_act(input logic pcsrc,
                                         input logic flush,
                                         input logic stall);
    if (pcsrc)      return ACT_REDIRECT;
    else if (flush) return ACT_FLUSH;
    else if (stall) return ACT_HOLD;
    else            return ACT_FETCH;
  endfunction

endpackage

// File: rtl/instr_mem.sv
// Word-addressed instruction memory: synchronous write, asynchronous read,
// NOP for reads beyond the populated depth. Contents are not reset.
module instr_mem
  import i_fetch_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 128
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(MEM_DEPTH)-1:0] waddr,
  input  logic [INSTR_W-1:0]           wdata,
  input  logic [29:0]                  raddr,
  output logic [INSTR_W-1:0]           rdata
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);

  logic [INSTR_W-1:0] mem [MEM_DEPTH];

  // Loader write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Range-checked combinational read; a same-edge write is seen only after the edge.
  always_comb begin
    rdata = NOP_INSTR;
    if ({2'b00, raddr} < 32'(MEM_DEPTH)) rdata = mem[raddr[AW-1:0]];
  end

endmodule

// File: rtl/i_fetch.sv
// Instruction-fetch stage: PC register, next-PC selection and IF/ID latch.
module i_fetch
  import i_fetch_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 128,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         EX_MEM_PCSrc,
  input  logic [31:0]                  EX_MEM_NPC,
  input  logic                         stall,
  input  logic                         flush,
  input  logic                         imem_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] imem_waddr,
  input  logic [INSTR_W-1:0]           imem_wdata,
  output logic [31:0]                  pc_out,
  output logic [INSTR_W-1:0]           IF_ID_instrout,
  output logic [31:0]                  IF_ID_npcout,
  output logic                         IF_ID_valid
);

  fetch_act_e         act;
  logic [31:0]        npc;
  logic [INSTR_W-1:0] instr;
  logic [31:0]        pc_d;
  logic [INSTR_W-1:0] instr_d;
  logic [31:0]        npc_d;
  logic               valid_d;

  assign npc = pc_out + PC_STEP;

  instr_mem #(
    .MEM_DEPTH(MEM_DEPTH)
  ) u_imem (
    .clk   (clk),
    .we    (imem_we),
    .waddr (imem_waddr),
    .wdata (imem_wdata),
    .raddr (pc_out[31:2]),
    .rdata (instr)
  );

  // Next PC and next IF/ID contents according to the edge action.
  always_comb begin
    act     = sel_act(EX_MEM_PCSrc, flush, stall);
    pc_d    = pc_out;
    instr_d = IF_ID_instrout;
    npc_d   = IF_ID_npcout;
    valid_d = IF_ID_valid;
    unique case (act)
      ACT_REDIRECT: begin
        pc_d    = EX_MEM_NPC & ~32'h3;
        instr_d = NOP_INSTR;
        npc_d   = '0;
        valid_d = 1'b0;
      end
      ACT_FLUSH: begin
        pc_d    = npc;
        instr_d = NOP_INSTR;
        npc_d   = '0;
        valid_d = 1'b0;
      end
      ACT_HOLD: begin
      end
      ACT_FETCH: begin
        pc_d    = npc;
        instr_d = instr;
        npc_d   = npc;
        valid_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // PC and IF/ID registers with asynchronous reset to a bubble at RESET_PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_out         <= RESET_PC;
      IF_ID_instrout <= NOP_INSTR;
      IF_ID_npcout   <= '0;
      IF_ID_valid    <= 1'b0;
    end else begin
      pc_out         <= pc_d;
      IF_ID_instrout <= instr_d;
      IF_ID_npcout   <= npc_d;
      IF_ID_valid    <= valid_d;
    end
  end

endmodule

// File: tb/tb_i_fetch.sv
// Directed self-checking bench for i_fetch.
module tb_i_fetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (MEM_DEPTH 128, RESET_PC 0)
  logic        rst_n = 1'b1;
  logic        pcsrc = 1'b0;
  logic [31:0] br_npc = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        we = 1'b0;
  logic [6:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] pc_out, instr_out, npc_out;
  logic        valid;

  // Boundary instance (MEM_DEPTH 16, RESET_PC at last word)
  logic        rst2_n = 1'b1;
  logic        pcsrc2 = 1'b0;
  logic [31:0] br_npc2 = '0;
  logic        stall2 = 1'b0;
  logic        flush2 = 1'b0;
  logic        we2 = 1'b0;
  logic [3:0]  waddr2 = '0;
  logic [31:0] wdata2 = '0;
  logic [31:0] pc2, instr2, npc2;
  logic        valid2;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [31:0] A0 = 32'hA000_0000, A1 = 32'hA111_1111,
                          A2 = 32'hA222_2222, A3 = 32'hA333_3333,
                          A16 = 32'hA160_0016, B = 32'hBBBB_0015,
                          C = 32'hCCCC_0002;

  i_fetch #(.MEM_DEPTH(128), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .EX_MEM_PCSrc(pcsrc), .EX_MEM_NPC(br_npc),
    .stall(stall), .flush(flush), .imem_we(we), .imem_waddr(waddr),
    .imem_wdata(wdata), .pc_out(pc_out), .IF_ID_instrout(instr_out),
    .IF_ID_npcout(npc_out), .IF_ID_valid(valid)
  );

  i_fetch #(.MEM_DEPTH(16), .RESET_PC(32'h0000_003C)) dut2 (
    .clk(clk), .rst_n(rst2_n), .EX_MEM_PCSrc(pcsrc2), .EX_MEM_NPC(br_npc2),
    .stall(stall2), .flush(flush2), .imem_we(we2), .imem_waddr(waddr2),
    .imem_wdata(wdata2), .pc_out(pc2), .IF_ID_instrout(instr2),
    .IF_ID_npcout(npc2), .IF_ID_valid(valid2)
  );

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0; rst2_n = 1'b0;
    #1;
    n_checks++;
    if ({pc_out, instr_out, npc_out, valid} !== {32'h0, 32'h0, 32'h0, 1'b0})
      $display("FAIL reset: got pc=%h ins=%h npc=%h v=%b want pc=0 ins=0 npc=0 v=0",
               pc_out, instr_out, npc_out, valid);
    else n_pass++;
    n_checks++;
    if ({pc2, instr2, npc2, valid2} !== {32'h3C, 32'h0, 32'h0, 1'b0})
      $display("FAIL reset2: got pc=%h ins=%h npc=%h v=%b want pc=3c ins=0 npc=0 v=0",
               pc2, instr2, npc2, valid2);
    else n_pass++;
    // Load memories while held in reset.
    we = 1'b1;
    waddr = 7'd0;  wdata = A0;  step();
    waddr = 7'd1;  wdata = A1;  step();
    waddr = 7'd2;  wdata = A2;  step();
    waddr = 7'd3;  wdata = A3;  step();
    waddr = 7'd16; wdata = A16; step();
    we = 1'b0;
    we2 = 1'b1; waddr2 = 4'd15; wdata2 = B; step();
    we2 = 1'b0;
    n_checks++;
    if ({pc_out, valid} !== {32'h0, 1'b0})
      $display("FAIL reset_hold: got pc=%h v=%b want pc=0 v=0", pc_out, valid);
    else n_pass++;
  endtask

  task automatic test_sequential_and_stall();
    rst_n = 1'b1;
    step();
    n_checks++;
    if ({pc_out, instr_out, npc_out, valid} !== {32'h4, A0, 32'h4, 1'b1})
      $display("FAIL seq0: got pc=%h ins=%h npc=%h v=%b want pc=4 ins=%h npc=4 v=1",
               pc_out, instr_out, npc_out, valid, A0);
    else n_pass++;
    step();
    n_checks++;
    if ({pc_out, instr_out, npc_out, valid} !== {32'h8, A1, 32'h8, 1'b1})
      $display("FAIL seq1: got pc=%h ins=%h npc=%h v=%b want pc=8 ins=%h npc=8 v=1",
               pc_out, instr_out, npc_out, valid, A1);
    else n_pass++;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({pc_out, instr_out, npc_out, valid} !== {32'h8, A1, 32'h8, 1'b1})
        $display("FAIL stall%0d: got pc=%h ins=%h npc=%h v=%b want pc=8 ins=%h npc=8 v=1",
                 i, pc_out, instr_out, npc_out, valid, A1);
      else n_pass++;
    end
    stall = 1'b0;
    step();
    n_checks++;
    if ({pc_out, instr_out, npc_out, valid} !== {32'hC, A2, 32'hC, 1'b1})
      $display("FAIL seq2: got pc=%h ins=%h npc=%h v=%b want pc=c ins=%h npc=c v=1",
               pc_out, instr_out, npc_out, valid, A2);
    else n_pass++;
    step();
    n_checks++;
    if ({pc_out, instr_out, npc_out, valid} !== {32'h10, A3, 32'h10, 1'b1})
      $display("FAIL seq3: got pc=%h ins=%h npc=%h v=%b want pc=10 ins=%h npc=10 v=1",
               pc_out, instr_out, npc_out, valid, A3);
    else n_pass++;
  endtask

  task automatic test_redirect();
    // Low address bits must be dropped; stall must not block the redirect.
    pcsrc = 1'b1; br_npc = 32'h0000_0043; stall = 1'b1;
    step();
    pcsrc = 1'b0; stall = 1'b0;
    n_checks++;
    if ({pc_out, instr_out, npc_out, valid} !== {32'h40, 32'h0, 32'h0, 1'b0})
      $display("FAIL redir_bubble: got pc=%h ins=%h npc=%h v=%b want pc=40 ins=0 npc=0 v=0",
               pc_out, instr_out, npc_out, valid);
    else n_pass++;
    step();
    n_checks++;
    if ({pc_out, instr_out, npc_out, valid} !== {32'h44, A16, 32'h44, 1'b1})
      $display("FAIL redir_target: got pc=%h ins=%h npc=%h v=%b want pc=44 ins=%h npc=44 v=1",
               pc_out, instr_out, npc_out, valid, A16);
    else n_pass++;
  endtask

  task automatic test_flush();
    pcsrc = 1'b1; br_npc = 32'h8;
    step();
    pcsrc = 1'b0; flush = 1'b1; stall = 1'b1;
    step();
    flush = 1'b0; stall = 1'b0;
    n_checks++;
    if ({pc_out, instr_out, npc_out, valid} !== {32'hC, 32'h0, 32'h0, 1'b0})
      $display("FAIL flush_bubble: got pc=%h ins=%h npc=%h v=%b want pc=c ins=0 npc=0 v=0",
               pc_out, instr_out, npc_out, valid);
    else n_pass++;
    step();
    n_checks++;
    if ({pc_out, instr_out, npc_out, valid} !== {32'h10, A3, 32'h10, 1'b1})
      $display("FAIL flush_next: got pc=%h ins=%h npc=%h v=%b want pc=10 ins=%h npc=10 v=1",
               pc_out, instr_out, npc_out, valid, A3);
    else n_pass++;
  endtask

  task automatic test_write_collision();
    pcsrc = 1'b1; br_npc = 32'h8;
    step();
    pcsrc = 1'b0;
    we = 1'b1; waddr = 7'd2; wdata = C;
    step();
    we = 1'b0;
    n_checks++;
    if ({pc_out, instr_out, npc_out, valid} !== {32'hC, A2, 32'hC, 1'b1})
      $display("FAIL wr_same_edge: got pc=%h ins=%h npc=%h v=%b want pc=c ins=%h npc=c v=1",
               pc_out, instr_out, npc_out, valid, A2);
    else n_pass++;
    pcsrc = 1'b1; br_npc = 32'h8;
    step();
    pcsrc = 1'b0;
    step();
    n_checks++;
    if ({pc_out, instr_out, npc_out, valid} !== {32'hC, C, 32'hC, 1'b1})
      $display("FAIL wr_refetch: got pc=%h ins=%h npc=%h v=%b want pc=c ins=%h npc=c v=1",
               pc_out, instr_out, npc_out, valid, C);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    stall = 1'b1; pcsrc = 1'b1; br_npc = 32'h40;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({pc_out, instr_out, npc_out, valid} !== {32'h0, 32'h0, 32'h0, 1'b0})
      $display("FAIL async_reset: got pc=%h ins=%h npc=%h v=%b want pc=0 ins=0 npc=0 v=0",
               pc_out, instr_out, npc_out, valid);
    else n_pass++;
    stall = 1'b0; pcsrc = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    n_checks++;
    if ({pc_out, instr_out, npc_out, valid} !== {32'h4, A0, 32'h4, 1'b1})
      $display("FAIL post_reset: got pc=%h ins=%h npc=%h v=%b want pc=4 ins=%h npc=4 v=1",
               pc_out, instr_out, npc_out, valid, A0);
    else n_pass++;
  endtask

  task automatic test_boundary();
    rst2_n = 1'b1;
    step();
    n_checks++;
    if ({pc2, instr2, npc2, valid2} !== {32'h40, B, 32'h40, 1'b1})
      $display("FAIL last_word: got pc=%h ins=%h npc=%h v=%b want pc=40 ins=%h npc=40 v=1",
               pc2, instr2, npc2, valid2, B);
    else n_pass++;
    step();
    n_checks++;
    if ({pc2, instr2, npc2, valid2} !== {32'h44, 32'h0, 32'h44, 1'b1})
      $display("FAIL out_of_range: got pc=%h ins=%h npc=%h v=%b want pc=44 ins=0 npc=44 v=1",
               pc2, instr2, npc2, valid2);
    else n_pass++;
    pcsrc2 = 1'b1; br_npc2 = 32'hFFFF_FFFF;
    step();
    pcsrc2 = 1'b0;
    n_checks++;
    if ({pc2, valid2} !== {32'hFFFF_FFFC, 1'b0})
      $display("FAIL top_redirect: got pc=%h v=%b want pc=fffffffc v=0", pc2, valid2);
    else n_pass++;
    step();
    n_checks++;
    if ({pc2, instr2, npc2, valid2} !== {32'h0, 32'h0, 32'h0, 1'b1})
      $display("FAIL pc_wrap: got pc=%h ins=%h npc=%h v=%b want pc=0 ins=0 npc=0 v=1",
               pc2, instr2, npc2, valid2);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sequential_and_stall();
    test_redirect();
    test_flush();
    test_write_collision();
    test_async_reset();
    test_boundary();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
